// File: rtl/sram_pkg.sv
// Shared constants for the sky130 32x512 SRAM macro, plus the bank-index helper
// used when tiling the macros into a deeper memory.
package sram_pkg;
    localparam int MACRO_DEPTH    = 512;
    localparam int MACRO_ADDR_LEN = 9;
    localparam int MACRO_WIDTH    = 32;
    localparam int MACRO_MASK_LEN = 4;

    function automatic int unsigned bank_idx(input logic [31:0] addr);
        return addr >> MACRO_ADDR_LEN;
    endfunction
endpackage

// File: rtl/sram_arb_wrapper_if.sv
// Port-A and shared-read-client bus of sram_arb_wrapper. The master side belongs
// to the load/fetch units and the slave side belongs to the wrapper.
interface sram_arb_wrapper_if #(
    parameter int ADDR_LEN  = 10,
    parameter int WORD_SIZE = 32,
    parameter int NUM_RD    = 2,
    parameter int ID_LEN    = 1
);
    logic                       a_en;
    logic                       a_we;
    logic [ADDR_LEN-1:0]        a_addr;
    logic [WORD_SIZE-1:0]       a_wdata;
    logic [WORD_SIZE/8-1:0]     a_wmask;
    logic [WORD_SIZE-1:0]       a_rdata;
    logic                       a_rvalid;
    logic [NUM_RD-1:0]          rd_req;
    logic [NUM_RD*ADDR_LEN-1:0] rd_addr;
    logic [NUM_RD-1:0]          rd_ready;
    logic [WORD_SIZE-1:0]       rd_rdata;
    logic                       rd_rvalid;
    logic [ID_LEN-1:0]          rd_rid;

    modport master (
        output a_en, a_we, a_addr, a_wdata, a_wmask, rd_req, rd_addr,
        input  a_rdata, a_rvalid, rd_ready, rd_rdata, rd_rvalid, rd_rid
    );
    modport slave (
        input  a_en, a_we, a_addr, a_wdata, a_wmask, rd_req, rd_addr,
        output a_rdata, a_rvalid, rd_ready, rd_rdata, rd_rvalid, rd_rid
    );
endinterface

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// Behavioural model of the sky130 1rw1r 32x512 macro: inputs captured on the
// clock edge, read data available for the whole following cycle.
module sky130_sram_2kbyte_1rw1r_32x512_8
    import sram_pkg::*;
(
    input  logic                      clk0,
    input  logic                      csb0,
    input  logic                      web0,
    input  logic [MACRO_MASK_LEN-1:0] wmask0,
    input  logic [MACRO_ADDR_LEN-1:0] addr0,
    input  logic [MACRO_WIDTH-1:0]    din0,
    output logic [MACRO_WIDTH-1:0]    dout0,
    input  logic                      clk1,
    input  logic                      csb1,
    input  logic [MACRO_ADDR_LEN-1:0] addr1,
    output logic [MACRO_WIDTH-1:0]    dout1
);
    logic [MACRO_WIDTH-1:0] mem [MACRO_DEPTH];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int k = 0; k < MACRO_MASK_LEN; k++)
                    if (wmask0[k]) mem[addr0][k*8 +: 8] <= din0[k*8 +: 8];
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= mem[addr1];
    end
endmodule

// File: rtl/sram_arb_wrapper_arb.sv
// Round-robin picker: the scan starts at ptr, and a grant is issued only when en
// is high. ptr advances past the winner only on an actual grant.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx
);
    logic [IDW-1:0] ptr;
    logic [N-1:0]   rot;
    logic           found;
    int             cand;

    assign rot = N'({req, req} >> ptr);

    always_comb begin
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                cand  = (int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k;
            end
        end
    end

    assign idx = IDW'(cand);
    assign gnt = (found && en) ? (N'(1) << cand) : '0;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (found && en)
            ptr <= (cand == N - 1) ? '0 : IDW'(cand + 1);
    end
endmodule

// File: rtl/sram_arb_wrapper.sv
// Tiles sky130 32x512 macros into a SIZE_IN_WORDS x WORD_SIZE memory with one
// read/write port and NUM_RD arbitrated read clients. Both ports have a fixed
// two-cycle read latency.
module sram_arb_wrapper
    import sram_pkg::*;
#(
    parameter int SIZE_IN_WORDS = 1024,
    parameter int WORD_SIZE     = 32,
    parameter int NUM_RD        = 2,
    parameter int ADDR_LEN      = $clog2(SIZE_IN_WORDS),
    parameter int ID_LEN        = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
    input logic              clk,
    input logic              rst,
    sram_arb_wrapper_if.slave bus
);
    localparam int LENGTH = SIZE_IN_WORDS / MACRO_DEPTH;
    localparam int WIDTH  = WORD_SIZE / MACRO_WIDTH;
    localparam int BANK_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    logic [NUM_RD-1:0]    gnt;
    logic [ID_LEN-1:0]    gidx;
    logic [ADDR_LEN-1:0]  cl_addr [NUM_RD];
    logic [ADDR_LEN-1:0]  g_addr;
    logic                 gnt_en, gnt_any;
    int unsigned          a_bank, g_bank;
    logic                 a_oor, g_oor;
    logic [WORD_SIZE-1:0] dout0_b [LENGTH];
    logic [WORD_SIZE-1:0] dout1_b [LENGTH];

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) cl_addr[k] = bus.rd_addr[k*ADDR_LEN +: ADDR_LEN];
    end

    assign g_addr = cl_addr[gidx];
    // A port-A write to the candidate's address blocks the grant; the client retries.
    assign gnt_en  = !rst && !(bus.a_en && bus.a_we && g_addr == bus.a_addr);
    assign gnt_any = |gnt;
    assign bus.rd_ready = gnt;

    assign a_bank = bank_idx(32'(bus.a_addr));
    assign g_bank = bank_idx(32'(g_addr));
    assign a_oor  = a_bank >= LENGTH;
    assign g_oor  = g_bank >= LENGTH;

    rr_arbiter #(.N(NUM_RD)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.rd_req),
        .en  (gnt_en),
        .gnt (gnt),
        .idx (gidx)
    );

    for (genvar b = 0; b < LENGTH; b++) begin : gen_bank
        logic                 csb0, csb1;
        logic [WORD_SIZE-1:0] dout0, dout1;

        assign csb0 = !(bus.a_en && !rst && a_bank == b);
        assign csb1 = !(gnt_any && g_bank == b);
        assign dout0_b[b] = dout0;
        assign dout1_b[b] = dout1;

        for (genvar j = 0; j < WIDTH; j++) begin : gen_col
            sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
                .clk0   (clk),
                .csb0   (csb0),
                .web0   (!bus.a_we),
                .wmask0 (bus.a_wmask[j*MACRO_MASK_LEN +: MACRO_MASK_LEN]),
                .addr0  (bus.a_addr[MACRO_ADDR_LEN-1:0]),
                .din0   (bus.a_wdata[j*MACRO_WIDTH +: MACRO_WIDTH]),
                .dout0  (dout0[j*MACRO_WIDTH +: MACRO_WIDTH]),
                .clk1   (clk),
                .csb1   (csb1),
                .addr1  (g_addr[MACRO_ADDR_LEN-1:0]),
                .dout1  (dout1[j*MACRO_WIDTH +: MACRO_WIDTH])
            );
        end
    end

    // Stage 1: request/grant accepted, macros capture the address.
    logic              a_vld_p1, rd_vld_p1;
    logic [BANK_W-1:0] a_bank_p1, rd_bank_p1;
    logic              a_oor_p1, rd_oor_p1;
    logic [ID_LEN-1:0] rd_rid_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_p1  <= 1'b0;
            rd_vld_p1 <= 1'b0;
        end else begin
            a_vld_p1  <= bus.a_en && !bus.a_we;
            rd_vld_p1 <= gnt_any;
        end
    end

    always_ff @(posedge clk) begin
        a_bank_p1  <= BANK_W'(a_bank);
        a_oor_p1   <= a_oor;
        rd_bank_p1 <= BANK_W'(g_bank);
        rd_oor_p1  <= g_oor;
        rd_rid_p1  <= gidx;
    end

    // Stage 2: selected bank's dout registered into the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.a_rvalid  <= 1'b0;
            bus.a_rdata   <= '0;
            bus.rd_rvalid <= 1'b0;
            bus.rd_rdata  <= '0;
            bus.rd_rid    <= '0;
        end else begin
            bus.a_rvalid  <= a_vld_p1;
            bus.rd_rvalid <= rd_vld_p1;
            if (a_vld_p1)
                bus.a_rdata <= a_oor_p1 ? '0 : dout0_b[a_bank_p1];
            if (rd_vld_p1) begin
                bus.rd_rdata <= rd_oor_p1 ? '0 : dout1_b[rd_bank_p1];
                bus.rd_rid   <= rd_rid_p1;
            end
        end
    end
endmodule

// File: tb/tb_sram_arb_wrapper.sv
// Directed bench for sram_arb_wrapper: a 1024-word, 2-client instance and a
// 1536-word instance that exercises out-of-range addressing.
module tb_sram_arb_wrapper;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sram_arb_wrapper_if #(.ADDR_LEN(10), .WORD_SIZE(32), .NUM_RD(2), .ID_LEN(1)) bus0 ();
    sram_arb_wrapper_if #(.ADDR_LEN(11), .WORD_SIZE(32), .NUM_RD(2), .ID_LEN(1)) bus1 ();

    sram_arb_wrapper #(.SIZE_IN_WORDS(1024), .WORD_SIZE(32), .NUM_RD(2)) d0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    sram_arb_wrapper #(.SIZE_IN_WORDS(1536), .WORD_SIZE(32), .NUM_RD(2)) d1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus0.a_en = 0; bus0.a_we = 0; bus0.a_addr = '0; bus0.a_wdata = '0; bus0.a_wmask = '0;
        bus0.rd_req = '0; bus0.rd_addr = '0;
        bus1.a_en = 0; bus1.a_we = 0; bus1.a_addr = '0; bus1.a_wdata = '0; bus1.a_wmask = '0;
        bus1.rd_req = '0; bus1.rd_addr = '0;
    endtask

    task automatic a_write0(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] mask);
        bus0.a_en = 1; bus0.a_we = 1; bus0.a_addr = addr; bus0.a_wdata = data; bus0.a_wmask = mask;
    endtask

    logic [10:0] wa1 [4];
    logic [31:0] wd1 [4];
    logic [10:0] ra1 [4];
    logic [31:0] rx1 [4];

    initial begin
        wa1 = '{11'h000, 11'h200, 11'h400, 11'h600};
        wd1 = '{32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 32'hFFFFFFFF};
        ra1 = '{11'h000, 11'h600, 11'h200, 11'h400};
        rx1 = '{32'h0000AAAA, 32'h0, 32'h0000BBBB, 32'h0000CCCC};

        // reset: requests are ignored, outputs held at zero
        rst = 1;
        idle();
        bus0.rd_req = 2'b11;
        bus0.a_en = 1;
        tick();
        #1 check("rst_ready", bus0.rd_ready, 2'b00);
        tick();
        check("rst_a_rvalid", bus0.a_rvalid, 0);
        check("rst_rd_rvalid", bus0.rd_rvalid, 0);
        check("rst_rd_rdata", bus0.rd_rdata, 0);
        check("rst_rd_rid", bus0.rd_rid, 0);
        check("rst_ptr", d0.u_arb.ptr, 0);
        rst = 0;
        idle();

        // port-A write, then client 1 reads it back
        a_write0(10'h205, 32'hDEADBEEF, 4'hF);
        tick();
        idle();
        bus0.rd_req = 2'b10;
        bus0.rd_addr = {10'h205, 10'h000};
        #1 check("wr_rd_ready", bus0.rd_ready, 2'b10);
        tick();
        bus0.rd_req = '0;
        check("wr_rd_early", bus0.rd_rvalid, 0);
        tick();
        check("wr_rd_rvalid", bus0.rd_rvalid, 1);
        check("wr_rd_rdata", bus0.rd_rdata, 32'hDEADBEEF);
        check("wr_rd_rid", bus0.rd_rid, 1);

        // partial write; port A and client 0 read the same word in one cycle
        a_write0(10'h033, 32'h11223344, 4'hF);
        tick();
        a_write0(10'h033, 32'hAABBCCDD, 4'b0101);
        tick();
        idle();
        bus0.a_en = 1; bus0.a_addr = 10'h033;
        bus0.rd_req = 2'b01; bus0.rd_addr = {10'h000, 10'h033};
        #1 check("pw_ready", bus0.rd_ready, 2'b01);
        tick();
        idle();
        check("pw_a_early", bus0.a_rvalid, 0);
        tick();
        check("pw_a_rvalid", bus0.a_rvalid, 1);
        check("pw_a_rdata", bus0.a_rdata, 32'h11BB33DD);
        check("pw_rd_rvalid", bus0.rd_rvalid, 1);
        check("pw_rd_rdata", bus0.rd_rdata, 32'h11BB33DD);
        check("pw_rd_rid", bus0.rd_rid, 0);
        check("pw_ptr", d0.u_arb.ptr, 1);

        // same-address write/read collision stalls the client for one cycle
        a_write0(10'h010, 32'hCAFE0010, 4'hF);
        bus0.rd_req = 2'b01; bus0.rd_addr = {10'h000, 10'h010};
        #1 check("col_stall", bus0.rd_ready, 2'b00);
        tick();
        check("col_ptr_hold", d0.u_arb.ptr, 1);
        bus0.a_en = 0; bus0.a_we = 0;
        #1 check("col_retry", bus0.rd_ready, 2'b01);
        tick();
        bus0.rd_req = '0;
        tick();
        check("col_rvalid", bus0.rd_rvalid, 1);
        check("col_rdata", bus0.rd_rdata, 32'hCAFE0010);
        check("col_rid", bus0.rd_rid, 0);

        // a write to a different address does not block the grant
        a_write0(10'h011, 32'h00000055, 4'hF);
        bus0.rd_req = 2'b10; bus0.rd_addr = {10'h205, 10'h000};
        #1 check("nocol_ready", bus0.rd_ready, 2'b10);
        tick();
        idle();
        tick();
        check("nocol_rdata", bus0.rd_rdata, 32'hDEADBEEF);
        check("nocol_rid", bus0.rd_rid, 1);

        // both clients request every cycle straight out of reset
        rst = 1;
        tick();
        rst = 0;
        bus0.rd_addr = {10'h205, 10'h010};
        for (int k = 0; k < 8; k++) begin
            bus0.rd_req = (k < 6) ? 2'b11 : 2'b00;
            #1;
            if (k < 6) check("rr_ready", bus0.rd_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k >= 2) begin
                check("rr_rvalid", bus0.rd_rvalid, 1);
                check("rr_rid", bus0.rd_rid, (k % 2 == 0) ? 0 : 1);
                check("rr_rdata", bus0.rd_rdata, (k % 2 == 0) ? 32'hCAFE0010 : 32'hDEADBEEF);
            end
            tick();
        end
        check("rr_drain", bus0.rd_rvalid, 0);

        // reset in the cycle after a grant discards the in-flight reads
        idle();
        bus0.rd_req = 2'b01; bus0.rd_addr = {10'h000, 10'h010};
        bus0.a_en = 1; bus0.a_addr = 10'h205;
        #1 check("mrst_grant", bus0.rd_ready, 2'b01);
        tick();
        rst = 1;
        idle();
        tick();
        rst = 0;
        check("mrst_rd_rvalid", bus0.rd_rvalid, 0);
        check("mrst_a_rvalid", bus0.a_rvalid, 0);
        check("mrst_rd_rdata", bus0.rd_rdata, 0);
        check("mrst_a_rdata", bus0.a_rdata, 0);
        check("mrst_rid", bus0.rd_rid, 0);
        check("mrst_ptr", d0.u_arb.ptr, 0);
        tick();
        check("mrst_rd_rvalid2", bus0.rd_rvalid, 0);
        check("mrst_a_rvalid2", bus0.a_rvalid, 0);

        // 1536 words: bank 3 (0x600..) is out of range
        for (int i = 0; i < 4; i++) begin
            bus1.a_en = 1; bus1.a_we = 1; bus1.a_addr = wa1[i];
            bus1.a_wdata = wd1[i]; bus1.a_wmask = 4'hF;
            tick();
        end
        idle();
        for (int k = 0; k < 6; k++) begin
            bus1.rd_req  = (k < 4) ? 2'b01 : 2'b00;
            bus1.rd_addr = (k < 4) ? {11'h000, ra1[k]} : '0;
            bus1.a_en    = (k < 2);
            bus1.a_addr  = (k == 0) ? 11'h200 : 11'h600;
            #1;
            if (k < 4) check("oor_ready", bus1.rd_ready, 2'b01);
            if (k >= 2) begin
                check("oor_rvalid", bus1.rd_rvalid, 1);
                check("oor_rdata", bus1.rd_rdata, rx1[k-2]);
                check("oor_rid", bus1.rd_rid, 0);
            end
            if (k == 2) check("oor_a_rdata_in", bus1.a_rdata, 32'h0000BBBB);
            if (k == 3) begin
                check("oor_a_rvalid", bus1.a_rvalid, 1);
                check("oor_a_rdata", bus1.a_rdata, 32'h0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
